cofre_prog: RTL
===============

# cofre_prog

Parametrised combination-lock controller, successor to the fixed 5-symbol vault FSM. It collects a sequence of `CODE_LEN` symbols of `SYM_W` bits and compares the whole entry against a stored code. It enforces a failed-attempt limit with a timed lockout, and lets the user reprogram the code while the vault is open. It sits between the keypad/symbol decoder and the vault actuator driver.

## Interface
- `SYM_W`, 2: bits per entered symbol.
- `CODE_LEN`, 5: symbols per code (≥1).
- `MAX_TRIES`, 3: consecutive failed entries that trigger lockout (≥1).
- `LOCKOUT_CYC`, 16: lockout duration in clk cycles (≥1).
- `DEFAULT_CODE`, 10'h25D: code loaded at reset, `CODE_LEN*SYM_W` bits. Symbol i is at bits `[i*SYM_W +: SYM_W]`, and symbol 0 is entered first. The default is the sequence 01,11,01,01,10.

Ports:
- `clk`, in, 1: clock; all state updates on the falling edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `sym_valid`, in, 1: `sym` carries a new symbol this cycle.
- `sym`, in, `SYM_W`: entered symbol; all values, including 0, are legal.
- `relock`, in, 1: close the vault (honoured in OPEN/PROG).
- `prog_en`, in, 1: request code reprogramming (honoured in OPEN).
- `unlocked`, out, 1: vault open; registered.
- `fail`, out, 1: one-cycle pulse after a wrong complete entry.
- `lockout`, out, 1: high while in LOCKOUT.
- `prog_busy`, out, 1: high while in PROG.
- `tries`, out, clog2(MAX_TRIES+1): consecutive failures so far.

## Operation
States: IDLE, ENTRY, OPEN, PROG, LOCKOUT.

- **Entry counter and buffer.** `idx` (clog2(CODE_LEN) bits) counts symbols received. Entered symbols are written to `entry_buf[idx]`.
- **IDLE.** On `sym_valid`, store the symbol at index 0, set `idx`=1, go to ENTRY. If CODE_LEN=1, compare immediately instead.
- **ENTRY.** Each `sym_valid` stores the symbol and increments `idx`. There is no early rejection; comparison happens only after the last symbol.
- **Completion of an entry** (CODE_LEN-th symbol sampled):
  - Full match: go to OPEN, clear `tries`.
  - Mismatch, `tries+1 < MAX_TRIES`: increment `tries`, pulse `fail`, go to IDLE.
  - Mismatch, `tries+1 == MAX_TRIES`: pulse `fail`, go to LOCKOUT, load the lockout timer with `LOCKOUT_CYC`.
- **OPEN.** `unlocked`=1. `relock` → IDLE. `prog_en` without `relock` → PROG with `idx`=0. `sym_valid` is ignored.
- **PROG.** `unlocked` stays 1. Symbols shift into a shadow register. After the CODE_LEN-th symbol, commit shadow to the code register in the same edge and return to OPEN. `relock` aborts: code unchanged, go to IDLE.
- **LOCKOUT.** All inputs are ignored. The timer decrements every cycle. When it reaches 0, go to IDLE and clear `tries`.
- **Priority:** `relock` > `prog_en` > `sym_valid`.
- **Reset values:** all outputs 0, state IDLE, `tries` 0, `idx` 0, code register = `DEFAULT_CODE`.
- **Reset mid-operation:** partial entries, partial PROG, and LOCKOUT are discarded. Any reprogrammed code reverts to `DEFAULT_CODE`.

## Timing
- **Sampling:** inputs are sampled on the falling edge of `clk`. Outputs change only after a falling edge or an asynchronous reset. Outputs are Moore/registered with no combinational input→output path.
- **Unlock latency:** `unlocked` rises at the edge that samples the last correct symbol.
- **Fail pulse:** `fail` is high for exactly one cycle after that edge.
- **Lockout timing:** `lockout` is high for exactly `LOCKOUT_CYC` cycles. The first symbol is accepted on the cycle after `lockout` falls.
- **Back-to-back symbols:** `sym_valid` may be high every cycle, so a full entry takes CODE_LEN cycles.
- **Entry after a failure:** a new entry may start on the cycle right after the `fail` edge.
- **Relock:** `relock` in OPEN drops `unlocked` at that edge.
- **Code commit:** a new code is effective from the edge after commit.

## Structure
- Shared package `cofre_pkg` holds:
  - the state enum, encoded as 3 bits (IDLE=0, ENTRY=1, OPEN=2, PROG=3, LOCKOUT=4);
  - the `DEFAULT_CODE` constant for the 2-bit/5-symbol configuration.
- One sub-module, `cofre_timer`: a loadable down-counter with a `done` flag, used for lockout.
- Comparison is a single CODE_LEN×SYM_W equality, inline in `cofre_prog`.

## Test plan
- **Default code:** after reset, enter 01,11,01,01,10 on consecutive cycles → `unlocked`=1 at the 5th edge; `fail`=0; `tries`=0.
- **Failures to lockout:** enter 01,11,01,01,11 three times → `fail` pulses ×3, `tries` counts 1,2; the third failure gives `lockout`=1 for 16 cycles. A correct code during lockout is ignored; after lockout the correct code opens.
- **Reprogramming:** open, assert `prog_en`, enter 00,00,11,10,01 → `prog_busy` for 5 cycles, back in OPEN. `relock`, then the old code → `fail`; the new code → `unlocked`.
- **Priority:** in OPEN, `relock`=`prog_en`=`sym_valid`=1 in one cycle → IDLE, `unlocked`=0, code unchanged.
- **Reset:** assert `rst`=0 asynchronously mid-PROG (after 3 symbols), and separately during lockout → all outputs 0 immediately; the default code opens afterwards.
- **Parameter sweep:** SYM_W=4, CODE_LEN=1, MAX_TRIES=1, LOCKOUT_CYC=1 → a single wrong symbol gives `fail` plus 1 cycle of `lockout`; a single correct symbol unlocks.

Source files
------------

// File: rtl/cofre_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cofre_pkg
//  Description : Shared types and constants for the cofre_prog combination
//                lock controller: FSM state encoding and the factory code for
//                the 2-bit / 5-symbol configuration.
//  Revision    : 1.0 - initial release
// ============================================================================
package cofre_pkg;

    // Controller states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_PROG    = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    // Factory code for SYM_W=2, CODE_LEN=5.
    // Symbol 0 (entered first) sits in the low bits: 01,11,01,01,10.
    localparam int unsigned c_def_sym_w    = 2;
    localparam int unsigned c_def_code_len = 5;
    localparam logic [c_def_sym_w*c_def_code_len-1:0] c_default_code = 10'h25D;

    // Width of a counter indexing n items; never below one bit so that a
    // single-symbol code still has a legal index register.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cofre_timer.sv
`default_nettype none
// ============================================================================
//  Module      : cofre_timer
//  Description : Loadable down-counter used for the lockout interval.
//                Loading sets the count to LOAD_VAL; afterwards it counts down
//                once per clock until it reaches zero and then holds.
//                o_done is high while the count is 1 or 0, i.e. when the
//                coming edge brings (or has brought) the count to zero.
//  Ports       : clk     - clock, falling-edge active
//                rst     - asynchronous reset, active low
//                i_load  - reload the counter with LOAD_VAL
//                o_done  - interval expires on the coming edge
//  Revision    : 1.0 - initial release
// ============================================================================
module cofre_timer #(
    parameter int unsigned WIDTH    = 5,
    parameter int unsigned LOAD_VAL = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    output logic o_done
);

    localparam logic [WIDTH-1:0] c_load = WIDTH'(LOAD_VAL);
    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= c_load;
        end else if (r_count != '0) begin
            r_count <= r_count - c_one;
        end
    end

    assign o_done = (r_count <= c_one);

endmodule
`default_nettype wire

// File: rtl/cofre_prog.sv
`default_nettype none
// ============================================================================
//  Module      : cofre_prog
//  Description : Parametrised combination-lock controller. Collects CODE_LEN
//                symbols, compares the full entry with the stored code, limits
//                consecutive failures with a timed lockout, and allows the code
//                to be reprogrammed while the vault is open.
//                All state updates happen on the falling edge of clk.
//  Ports       : clk       - clock, falling-edge active
//                rst       - asynchronous reset, active low
//                sym_valid - sym carries a new symbol this cycle
//                sym       - entered symbol
//                relock    - close the vault (OPEN/PROG)
//                prog_en   - request reprogramming (OPEN)
//                unlocked  - vault open (registered)
//                fail      - one-cycle pulse after a wrong complete entry
//                lockout   - high while locked out
//                prog_busy - high while reprogramming
//                tries     - consecutive failed entries
//  Revision    : 1.0 - initial release
// ============================================================================
module cofre_prog
    import cofre_pkg::*;
#(
    parameter int unsigned                 SYM_W        = 2,
    parameter int unsigned                 CODE_LEN     = 5,
    parameter int unsigned                 MAX_TRIES    = 3,
    parameter int unsigned                 LOCKOUT_CYC  = 16,
    parameter logic [CODE_LEN*SYM_W-1:0]   DEFAULT_CODE = c_default_code
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               sym_valid,
    input  logic [SYM_W-1:0]                   sym,
    input  logic                               relock,
    input  logic                               prog_en,
    output logic                               unlocked,
    output logic                               fail,
    output logic                               lockout,
    output logic                               prog_busy,
    output logic [$clog2(MAX_TRIES+1)-1:0]     tries
);

    localparam int unsigned c_code_w  = CODE_LEN * SYM_W;
    localparam int unsigned c_idx_w   = idx_width(CODE_LEN);
    localparam int unsigned c_tries_w = $clog2(MAX_TRIES + 1);
    localparam int unsigned c_tmr_w   = $clog2(LOCKOUT_CYC + 1);

    localparam logic [c_idx_w-1:0]   c_last_idx = c_idx_w'(CODE_LEN - 1);
    localparam logic [c_idx_w-1:0]   c_idx_one  = c_idx_w'(1);
    localparam logic [c_tries_w-1:0] c_last_try = c_tries_w'(MAX_TRIES - 1);
    localparam logic [c_tries_w-1:0] c_try_one  = c_tries_w'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 r_state;
    logic [c_idx_w-1:0]     r_idx;
    logic [c_tries_w-1:0]   r_tries;
    logic [c_code_w-1:0]    r_code;
    logic [c_code_w-1:0]    r_entry;
    logic [c_code_w-1:0]    r_shadow;
    logic                   r_fail;
    logic                   r_unlocked;
    logic                   r_lockout;
    logic                   r_prog_busy;

    state_t                 w_state_n;
    logic [c_idx_w-1:0]     w_idx_n;
    logic [c_tries_w-1:0]   w_tries_n;
    logic [c_code_w-1:0]    w_code_n;
    logic [c_code_w-1:0]    w_entry_n;
    logic [c_code_w-1:0]    w_shadow_n;
    logic                   w_fail_n;
    logic                   w_tmr_load;
    logic                   w_tmr_done;

    // Entry / shadow contents with the current symbol dropped into slot idx.
    // The last symbol is never stored before comparison: the compare uses
    // this merged view so the decision is made on the same edge.
    logic [c_code_w-1:0]    w_entry_ins;
    logic [c_code_w-1:0]    w_shadow_ins;
    logic                   w_last_sym;
    logic                   w_match;

    always_comb begin
        w_entry_ins  = r_entry;
        w_shadow_ins = r_shadow;
        w_entry_ins[r_idx*SYM_W +: SYM_W]  = sym;
        w_shadow_ins[r_idx*SYM_W +: SYM_W] = sym;
    end

    assign w_last_sym = (r_idx == c_last_idx);
    assign w_match    = (w_entry_ins == r_code);

    // ------------------------------------------------------------------
    // Lockout timer
    // ------------------------------------------------------------------
    cofre_timer #(
        .WIDTH    (c_tmr_w),
        .LOAD_VAL (LOCKOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_tmr_load),
        .o_done (w_tmr_done)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_n  = r_state;
        w_idx_n    = r_idx;
        w_tries_n  = r_tries;
        w_code_n   = r_code;
        w_entry_n  = r_entry;
        w_shadow_n = r_shadow;
        w_fail_n   = 1'b0;
        w_tmr_load = 1'b0;

        case (r_state)
            // IDLE and ENTRY share the collection path; idx is 0 in IDLE,
            // so a one-symbol code completes straight from IDLE.
            ST_IDLE, ST_ENTRY: begin
                if (sym_valid) begin
                    w_entry_n = w_entry_ins;
                    if (w_last_sym) begin
                        w_idx_n = '0;
                        if (w_match) begin
                            w_state_n = ST_OPEN;
                            w_tries_n = '0;
                        end else begin
                            w_fail_n  = 1'b1;
                            w_tries_n = r_tries + c_try_one;
                            if (r_tries == c_last_try) begin
                                w_state_n  = ST_LOCKOUT;
                                w_tmr_load = 1'b1;
                            end else begin
                                w_state_n = ST_IDLE;
                            end
                        end
                    end else begin
                        w_idx_n   = r_idx + c_idx_one;
                        w_state_n = ST_ENTRY;
                    end
                end
            end

            ST_OPEN: begin
                if (relock) begin
                    w_state_n = ST_IDLE;
                end else if (prog_en) begin
                    w_state_n = ST_PROG;
                    w_idx_n   = '0;
                end
            end

            ST_PROG: begin
                if (relock) begin
                    w_state_n = ST_IDLE;
                    w_idx_n   = '0;
                end else if (sym_valid) begin
                    w_shadow_n = w_shadow_ins;
                    if (w_last_sym) begin
                        w_code_n  = w_shadow_ins;
                        w_idx_n   = '0;
                        w_state_n = ST_OPEN;
                    end else begin
                        w_idx_n = r_idx + c_idx_one;
                    end
                end
            end

            ST_LOCKOUT: begin
                if (w_tmr_done) begin
                    w_state_n = ST_IDLE;
                    w_tries_n = '0;
                end
            end

            default: begin
                w_state_n = ST_IDLE;
                w_idx_n   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers; outputs are decoded from the next state so they change
    // on the same edge as the state itself.
    // ------------------------------------------------------------------
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_tries     <= '0;
            r_code      <= DEFAULT_CODE;
            r_entry     <= '0;
            r_shadow    <= '0;
            r_fail      <= 1'b0;
            r_unlocked  <= 1'b0;
            r_lockout   <= 1'b0;
            r_prog_busy <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_idx       <= w_idx_n;
            r_tries     <= w_tries_n;
            r_code      <= w_code_n;
            r_entry     <= w_entry_n;
            r_shadow    <= w_shadow_n;
            r_fail      <= w_fail_n;
            r_unlocked  <= (w_state_n == ST_OPEN) || (w_state_n == ST_PROG);
            r_lockout   <= (w_state_n == ST_LOCKOUT);
            r_prog_busy <= (w_state_n == ST_PROG);
        end
    end

    assign unlocked  = r_unlocked;
    assign fail      = r_fail;
    assign lockout   = r_lockout;
    assign prog_busy = r_prog_busy;
    assign tries     = r_tries;

endmodule
`default_nettype wire
